// File: rtl/rr_fifo_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_fifo_read_scheduler
// Description : Work-conserving round-robin read scheduler for four external
//               DEPTH-entry FIFO queues that share one valid/ready output.
//               Gates producer write enables against queue occupancy, tracks
//               each queue's fill level, issues at most one one-hot read per
//               cycle (skipping empty queues) and registers the selected head
//               word into a single-entry output stage.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               wen    [3:0]      - producer write requests
//               wen_q  [3:0]      - gated write enables to the queues
//               ren_q  [3:0]      - one-hot (or zero) read enables
//               q_dout [4*DW-1:0] - queue head words, queue i at [i*DW +: DW]
//               dout, out_src,
//               out_valid         - registered output word / source / valid
//               out_ready         - consumer accept
//               full, empty [3:0] - occupancy flags
//               wr_drop [3:0]     - one-cycle pulse after a refused write
// Revision    : 1.0 - initial release
// ============================================================================
module rr_fifo_read_scheduler #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      wen,
    output logic [3:0]      wen_q,
    output logic [3:0]      ren_q,
    input  logic [4*DW-1:0] q_dout,
    output logic [DW-1:0]   dout,
    output logic [1:0]      out_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      full,
    output logic [3:0]      empty,
    output logic [3:0]      wr_drop
);

    localparam int              c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt [4];
    logic [1:0]         r_rr_ptr;
    logic [DW-1:0]      r_dout;
    logic [1:0]         r_out_src;
    logic               r_out_valid;
    logic [3:0]         r_wr_drop;

    logic [3:0]         w_eligible;
    logic               w_slot_free;
    logic               w_issue;
    logic [1:0]         w_grant_idx;

    // ------------------------------------------------------------------------
    // Per-queue occupancy tracking and write gating
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_queue
            assign full[gi]  = (r_cnt[gi] == c_depth);
            assign empty[gi] = (r_cnt[gi] == '0);
            // A full queue refuses the write even if it is read this cycle.
            assign wen_q[gi] = rst_n & wen[gi] & ~full[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[gi] <= '0;
                end else begin
                    case ({wen_q[gi], ren_q[gi]})
                        2'b10:   r_cnt[gi] <= r_cnt[gi] + c_one;
                        2'b01:   r_cnt[gi] <= r_cnt[gi] - c_one;
                        default: r_cnt[gi] <= r_cnt[gi];
                    endcase
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------------
    // Eligibility looks only at registered counts, so a write lands in the
    // arbitration one cycle after it is accepted.
    assign w_eligible  = ~empty;
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_issue     = rst_n & w_slot_free & (|w_eligible);

    always_comb begin
        logic       found;
        logic [1:0] cand;
        found       = 1'b0;
        cand        = r_rr_ptr;
        w_grant_idx = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            cand = r_rr_ptr + 2'(k);
            if (!found && w_eligible[cand]) begin
                found       = 1'b1;
                w_grant_idx = cand;
            end
        end
    end

    assign ren_q = w_issue ? (4'b0001 << w_grant_idx) : 4'b0000;

    // ------------------------------------------------------------------------
    // Output stage, pointer and drop flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_wr_drop   <= '0;
        end else begin
            r_wr_drop <= wen & full;
            if (w_issue) begin
                r_dout      <= q_dout[w_grant_idx*DW +: DW];
                r_out_src   <= w_grant_idx;
                r_out_valid <= 1'b1;
                r_rr_ptr    <= w_grant_idx + 2'd1;
            end else if (r_out_valid && out_ready) begin
                // Word consumed with nothing to replace it; data is kept.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;
    assign wr_drop   = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_rr_fifo_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_fifo_read_scheduler
// Description : Directed self-checking bench for rr_fifo_read_scheduler.
//               Models the four external queues, keeps a per-queue scoreboard
//               of written words and checks every consumed output word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_fifo_read_scheduler;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  wen;
    logic [3:0]  wen_q;
    logic [3:0]  ren_q;
    logic [31:0] q_dout;
    logic [7:0]  dout;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  wr_drop;

    logic [7:0]  wdata [4];
    logic [7:0]  env [4][$];   // external queue contents
    logic [7:0]  sb  [4][$];   // expected words per source queue
    logic [3:0]  m_w;
    logic [3:0]  m_r;
    logic [7:0]  m_d [4];
    logic [7:0]  e_word;

    int total;
    int bad;

    rr_fifo_read_scheduler #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (wen),
        .wen_q     (wen_q),
        .ren_q     (ren_q),
        .q_dout    (q_dout),
        .dout      (dout),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .wr_drop   (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh_heads();
        for (int i = 0; i < 4; i++)
            q_dout[i*8 +: 8] = (env[i].size() != 0) ? env[i][0] : 8'h00;
    endtask

    // External queues: sample enables at the edge, update 1 time unit later.
    always begin
        @(posedge clk);
        m_w = wen_q;
        m_r = ren_q;
        for (int i = 0; i < 4; i++) m_d[i] = wdata[i];
        #1;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (m_r[i] && env[i].size() != 0) void'(env[i].pop_front());
                if (m_w[i]) env[i].push_back(m_d[i]);
            end
        end
        refresh_heads();
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 4; i++) env[i].delete();
        refresh_heads();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Word is consumed at the next rising edge; compare against scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_pending", 32'(sb[out_src].size() != 0), 32'd1);
            if (sb[out_src].size() != 0) begin
                e_word = sb[out_src].pop_front();
                chk("sb_data", 32'(dout), 32'(e_word));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive a write and record every word the queue will accept.
    task automatic drive_wr(input logic [3:0] m, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        wdata[0] = d0; wdata[1] = d1; wdata[2] = d2; wdata[3] = d3;
        wen = m;
        for (int i = 0; i < 4; i++)
            if (m[i] && env[i].size() < DEPTH) sb[i].push_back(wdata[i]);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        wen = 4'b0000;
        out_ready = 1'b1;
        while ((out_valid || !(&empty)) && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 40), 32'd1);
    endtask

    initial begin
        logic [1:0] seq [6];
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        wen = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wdata[i] = 8'h00;
        q_dout = 32'h0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ren_q", 32'(ren_q), 32'h0);
        chk("rst_wen_q", 32'(wen_q), 32'h0);
        chk("rst_wr_drop", 32'(wr_drop), 32'h0);
        wen = 4'b0000;
        rst_n = 1'b1;
        step();

        // ---------------- round robin with skip ----------------
        out_ready = 1'b1;
        drive_wr(4'b1011, 8'h10, 8'h20, 8'h00, 8'h30);
        step();
        drive_wr(4'b1011, 8'h11, 8'h21, 8'h00, 8'h31);
        step();
        wen = 4'b0000;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3;
        seq[3] = 2'd0; seq[4] = 2'd1; seq[5] = 2'd3;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("rr_src_%0d", k), 32'(out_src), 32'(seq[k]));
            step();
        end
        chk("rr_valid_drop", 32'(out_valid), 32'd0);

        // ---------------- single write latency ----------------
        drive_wr(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00);
        #1;
        chk("sw_wen_q", 32'(wen_q), 32'h1);
        step();
        wen = 4'b0000;
        chk("sw_ren_q", 32'(ren_q), 32'h1);
        chk("sw_valid_n1", 32'(out_valid), 32'd0);
        step();
        chk("sw_valid", 32'(out_valid), 32'd1);
        chk("sw_dout", 32'(dout), 32'h5A);
        chk("sw_src", 32'(out_src), 32'd0);
        chk("sw_empty0", 32'(empty[0]), 32'd1);
        step();
        chk("sw_valid_drop", 32'(out_valid), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        drive_wr(4'b0010, 8'h00, 8'h40, 8'h00, 8'h00);
        step();
        drive_wr(4'b0010, 8'h00, 8'h41, 8'h00, 8'h00);
        step();
        drive_wr(4'b0011, 8'h50, 8'h42, 8'h00, 8'h00);
        step();
        wen = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_ren_%0d", k), 32'(ren_q), 32'h0);
            chk($sformatf("bp_dout_%0d", k), 32'(dout), 32'h40);
            chk($sformatf("bp_src_%0d", k), 32'(out_src), 32'd1);
            chk($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_empty_%0d", k), 32'(empty), 32'hC);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ren", 32'(ren_q), 32'h1);
        step();
        chk("bp_nb_valid0", 32'(out_valid), 32'd1);
        chk("bp_nb_src0", 32'(out_src), 32'd0);
        chk("bp_nb_dout0", 32'(dout), 32'h50);
        step();
        chk("bp_nb_src1", 32'(out_src), 32'd1);
        chk("bp_nb_dout1", 32'(dout), 32'h41);
        step();
        chk("bp_nb_dout2", 32'(dout), 32'h42);
        step();
        chk("bp_valid_drop", 32'(out_valid), 32'd0);

        // ---------------- full / drop ----------------
        out_ready = 1'b0;
        drive_wr(4'b1000, 8'h00, 8'h00, 8'h00, 8'h60);
        step();
        wen = 4'b0000;
        step();
        chk("fd_slot_valid", 32'(out_valid), 32'd1);
        chk("fd_slot_src", 32'(out_src), 32'd3);
        for (int k = 0; k < 9; k++) begin
            drive_wr(4'b0100, 8'h00, 8'h00, 8'(8'h70 + k), 8'h00);
            #1;
            if (k == 8) begin
                chk("fd_full_after8", 32'(full), 32'h4);
                chk("fd_wen_q_refused", 32'(wen_q), 32'h0);
            end else begin
                chk($sformatf("fd_wen_q_%0d", k), 32'(wen_q), 32'h4);
            end
            step();
        end
        wen = 4'b0000;
        chk("fd_wr_drop", 32'(wr_drop), 32'h4);
        step();
        chk("fd_wr_drop_clear", 32'(wr_drop), 32'h0);
        out_ready = 1'b1;
        drive_wr(4'b0100, 8'h00, 8'h00, 8'h7F, 8'h00);
        #1;
        chk("fd_wr_full_ren", 32'(ren_q), 32'h4);
        chk("fd_wr_full_wen_q", 32'(wen_q), 32'h0);
        step();
        wen = 4'b0000;
        chk("fd_cnt7_notfull", 32'(full), 32'h0);
        chk("fd_wr_drop2", 32'(wr_drop), 32'h4);
        chk("fd_src2", 32'(out_src), 32'd2);
        chk("fd_dout2", 32'(dout), 32'h70);
        drain("fd_drain");

        // ---------------- simultaneous write/read ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_wr(4'b0010, 8'h00, 8'(8'h81 + k), 8'h00, 8'h00);
            step();
        end
        wen = 4'b0000;
        chk("sim_empty_pre", 32'(empty), 32'hD);
        chk("sim_slot_dout", 32'(dout), 32'h81);
        out_ready = 1'b1;
        drive_wr(4'b1010, 8'h00, 8'h86, 8'h00, 8'h90);
        #1;
        chk("sim_ren_q1", 32'(ren_q), 32'h2);
        chk("sim_wen_q", 32'(wen_q), 32'hA);
        step();
        wen = 4'b0000;
        chk("sim_empty_post", 32'(empty), 32'h5);
        chk("sim_ren_q3_next", 32'(ren_q), 32'h8);
        drain("sim_drain");

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_wr(4'b0001, 8'(8'hA0 + k), 8'h00, 8'h00, 8'h00);
            step();
        end
        wen = 4'b0000;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_empty", 32'(empty), 32'hE);
        wen = 4'b0001;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_dout", 32'(dout), 32'd0);
        chk("ar_empty", 32'(empty), 32'hF);
        chk("ar_ren_q", 32'(ren_q), 32'h0);
        chk("ar_wen_q", 32'(wen_q), 32'h0);
        for (int i = 0; i < 4; i++) sb[i].delete();
        step();
        wen = 4'b0000;
        step();
        rst_n = 1'b1;
        drive_wr(4'b0101, 8'hB0, 8'h00, 8'hC0, 8'h00);
        #1;
        chk("ar_post_wen_q", 32'(wen_q), 32'h5);
        step();
        wen = 4'b0000;
        chk("ar_first_grant", 32'(ren_q), 32'h1);
        drain("ar_drain");

        chk("end_sb_empty", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'd0);
        chk("end_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
